// File: rtl/ddr_clk_pkg.sv
// Shared types and defaults for the DDR clock-tree sequencing blocks
// (edge-clock sync, read leveling, DQS update).
package ddr_clk_pkg;

  typedef enum logic [2:0] {
    S_LOCK,
    S_FREEZE,
    S_STOP,
    S_ACT,
    S_UNSTOP,
    S_UNFREEZE,
    S_READY
  } seq_state_t;

  localparam int DEF_LOCK_FILTER = 16;
  localparam int DEF_PHASE_CYC   = 8;
  localparam int DEF_UPD_CYC     = 4;

  // Width large enough to hold the larger of two cycle counts without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ddr_lock_filter.sv
// Consecutive-high filter on pll_lock & dll_lock; flags a stable lock and
// pulses when the combined lock falls.
module ddr_lock_filter
  import ddr_clk_pkg::*;
#(
  parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic dll_lock,
  output logic locked_stable,
  output logic lock_drop
);

  localparam int CW = $clog2(LOCK_FILTER + 1);
  localparam logic [CW-1:0] SAT  = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] LAST = CW'(LOCK_FILTER - 1);

  logic          both;
  logic          both_q;
  logic [CW-1:0] cnt;

  assign both = pll_lock & dll_lock;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      both_q <= 1'b0;
    end else begin
      both_q <= both;
      if (!both)
        cnt <= '0;
      else if (cnt != SAT)
        cnt <= cnt + CW'(1);
    end
  end

  // The cycle that completes the run of LOCK_FILTER highs is itself stable.
  assign locked_stable = both && (cnt >= LAST);
  assign lock_drop     = both_q && !both;

endmodule

// File: rtl/ddr_eclk_sync_seq.sv
// DDR edge-clock start/stop sequencer: brings up ECLKSYNCB/DDRDLLA/CLKDIVF
// after lock and runs glitch-free DLL code updates on request.
module ddr_eclk_sync_seq
  import ddr_clk_pkg::*;
#(
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int PHASE_CYC   = DEF_PHASE_CYC,
  parameter int UPD_CYC     = DEF_UPD_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic dll_lock,
  input  logic update_req,
  output logic eclk_stop,
  output logic dll_freeze,
  output logic uddcntln,
  output logic ddr_rst,
  output logic ready,
  output logic update_ack,
  output logic lock_lost
);

  localparam int CW = cnt_width(LOCK_FILTER, PHASE_CYC);
  localparam logic [CW-1:0] PH_LAST  = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] UPD_LAST = CW'(UPD_CYC - 1);

  seq_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          init_pass, init_pass_n;
  logic          pending, pending_n;
  logic          eclk_stop_n, dll_freeze_n, uddcntln_n, ddr_rst_n;
  logic          ready_n, update_ack_n, lock_lost_n;
  logic          locked_stable, lock_drop;
  logic          phase_done;

  ddr_lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .dll_lock     (dll_lock),
    .locked_stable(locked_stable),
    .lock_drop    (lock_drop)
  );

  assign phase_done = (cnt == PH_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_LOCK;
      cnt        <= '0;
      init_pass  <= 1'b1;
      pending    <= 1'b0;
      eclk_stop  <= 1'b1;
      dll_freeze <= 1'b0;
      uddcntln   <= 1'b1;
      ddr_rst    <= 1'b1;
      ready      <= 1'b0;
      update_ack <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      init_pass  <= init_pass_n;
      pending    <= pending_n;
      eclk_stop  <= eclk_stop_n;
      dll_freeze <= dll_freeze_n;
      uddcntln   <= uddcntln_n;
      ddr_rst    <= ddr_rst_n;
      ready      <= ready_n;
      update_ack <= update_ack_n;
      lock_lost  <= lock_lost_n;
    end
  end

  always_comb begin
    state_n      = state;
    init_pass_n  = init_pass;
    pending_n    = pending;
    eclk_stop_n  = eclk_stop;
    dll_freeze_n = dll_freeze;
    uddcntln_n   = uddcntln;
    ddr_rst_n    = ddr_rst;
    ready_n      = ready;
    update_ack_n = 1'b0;
    lock_lost_n  = 1'b0;

    if (update_req && (state != S_READY))
      pending_n = 1'b1;

    // A lock drop outranks everything else and throws the tree back to reset.
    if ((state != S_LOCK) && lock_drop) begin
      state_n      = S_LOCK;
      eclk_stop_n  = 1'b1;
      ddr_rst_n    = 1'b1;
      dll_freeze_n = 1'b0;
      uddcntln_n   = 1'b1;
      ready_n      = 1'b0;
      lock_lost_n  = 1'b1;
      init_pass_n  = 1'b1;
      pending_n    = 1'b0;
    end else begin
      case (state)
        S_LOCK: begin
          if (locked_stable) begin
            state_n      = S_FREEZE;
            dll_freeze_n = 1'b1;
          end
        end
        S_FREEZE: begin
          if (phase_done) begin
            state_n     = S_STOP;
            eclk_stop_n = 1'b1;
          end
        end
        S_STOP: begin
          if (phase_done) begin
            state_n = S_ACT;
            if (init_pass)
              ddr_rst_n = 1'b0;
            else
              uddcntln_n = 1'b0;
          end
        end
        S_ACT: begin
          if (!init_pass && (cnt == UPD_LAST))
            uddcntln_n = 1'b1;
          if (phase_done) begin
            state_n     = S_UNSTOP;
            eclk_stop_n = 1'b0;
          end
        end
        S_UNSTOP: begin
          if (phase_done) begin
            state_n      = S_UNFREEZE;
            dll_freeze_n = 1'b0;
          end
        end
        S_UNFREEZE: begin
          if (phase_done) begin
            state_n      = S_READY;
            ready_n      = 1'b1;
            update_ack_n = !init_pass;
            init_pass_n  = 1'b0;
            // Requests seen while bringing the tree up for the first time are moot.
            if (init_pass)
              pending_n = 1'b0;
          end
        end
        S_READY: begin
          if (update_req || pending) begin
            state_n      = S_FREEZE;
            ready_n      = 1'b0;
            pending_n    = 1'b0;
            dll_freeze_n = 1'b1;
          end
        end
        default: state_n = S_LOCK;
      endcase
    end

    if (state_n != state)
      cnt_n = '0;
    else if (state == S_LOCK)
      cnt_n = '0;
    else if (cnt != '1)
      cnt_n = cnt + CW'(1);
    else
      cnt_n = cnt;
  end

endmodule

// File: tb/tb_ddr_eclk_sync_seq.sv
// Directed bench for ddr_eclk_sync_seq: init bring-up, lock glitch, update
// passes, request merging, lock loss and reset mid-sequence.
module tb_ddr_eclk_sync_seq;

  logic clk;
  logic rst_n;
  logic pll_lock;
  logic dll_lock;
  logic update_req;
  logic eclk_stop;
  logic dll_freeze;
  logic uddcntln;
  logic ddr_rst;
  logic ready;
  logic update_ack;
  logic lock_lost;
  logic [6:0] outs;

  int checks;
  int failures;
  int ack_cnt;

  ddr_eclk_sync_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .dll_lock  (dll_lock),
    .update_req(update_req),
    .eclk_stop (eclk_stop),
    .dll_freeze(dll_freeze),
    .uddcntln  (uddcntln),
    .ddr_rst   (ddr_rst),
    .ready     (ready),
    .update_ack(update_ack),
    .lock_lost (lock_lost)
  );

  assign outs = {eclk_stop, dll_freeze, uddcntln, ddr_rst, ready, update_ack, lock_lost};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LOST_VEC = 7'b1011001;

  // Expected outputs e edges into an init pass (e=0: reset / idle in S_LOCK).
  function automatic logic [6:0] init_vec(input int e);
    logic s, f, u, r, rd;
    s  = (e < 40);
    f  = (e >= 16) && (e <= 47);
    u  = 1'b1;
    r  = (e < 32);
    rd = (e >= 56);
    return {s, f, u, r, rd, 1'b0, 1'b0};
  endfunction

  // Expected outputs r edges after update_req is sampled in S_READY.
  function automatic logic [6:0] upd_vec(input int r);
    logic s, f, u, rd, a;
    s  = (r >= 8) && (r < 24);
    f  = (r < 32);
    u  = !((r >= 16) && (r < 20));
    rd = (r >= 40);
    a  = (r == 40);
    return {s, f, u, 1'b0, rd, a, 1'b0};
  endfunction

  task automatic applyStimulus(input logic rst_v, input logic pll_v, input logic dll_v,
                               input logic req_v);
    rst_n      = rst_v;
    pll_lock   = pll_v;
    dll_lock   = dll_v;
    update_req = req_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [6:0] obs,
                             input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    pll_lock   = 1'b1;
    dll_lock   = 1'b1;
    update_req = 1'b0;

    $display("[TB] test 1: init bring-up, request in S_LOCK absorbed");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset", 0, outs, init_vec(0));
    for (int e = 1; e <= 60; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, e == 5);
      checkOutput("init", e, outs, init_vec(e));
    end

    $display("[TB] test 2: dll_lock glitch restarts the lock filter");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset2", 0, outs, init_vec(0));
    for (int e = 1; e <= 67; e++) begin
      applyStimulus(1'b1, 1'b1, e != 11, 1'b0);
      checkOutput("glitch", e, outs, init_vec((e <= 11) ? 0 : e - 11));
    end

    $display("[TB] test 3: single update pass");
    for (int r = 0; r <= 41; r++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, r == 0);
      checkOutput("upd", r, outs, upd_vec(r));
    end

    $display("[TB] test 4: held request during S_STOP merges into one extra pass");
    ack_cnt = 0;
    for (int r = 0; r <= 90; r++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, (r == 0) || ((r >= 10) && (r <= 12)));
      checkOutput("merge", r, outs, (r <= 40) ? upd_vec(r) : upd_vec(r - 41));
      if (update_ack) ack_cnt++;
    end
    checkOutput("ack_count", 0, 7'(ack_cnt), 7'd2);

    $display("[TB] test 5: pll_lock drop in S_UNSTOP of an update pass");
    for (int r = 0; r <= 86; r++) begin
      applyStimulus(1'b1, !((r >= 26) && (r <= 29)), 1'b1, r == 0);
      if (r < 26)
        checkOutput("drop", r, outs, upd_vec(r));
      else if (r == 26)
        checkOutput("drop", r, outs, LOST_VEC);
      else if (r <= 29)
        checkOutput("drop", r, outs, init_vec(0));
      else
        checkOutput("drop", r, outs, init_vec(r - 29));
    end

    $display("[TB] test 6: reset in S_ACT with a pending request");
    for (int r = 0; r <= 119; r++) begin
      applyStimulus(r != 18, 1'b1, 1'b1, (r == 0) || (r == 5));
      if (r < 18)
        checkOutput("rstact", r, outs, upd_vec(r));
      else if (r == 18)
        checkOutput("rstact", r, outs, init_vec(0));
      else
        checkOutput("rstact", r, outs, init_vec(r - 18));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
